// File: rtl/input_devices.sv
// CPU read-side peripheral block: a resynchronised level port at 0x00, an event FIFO at 0x01,
// and a FIFO status word at 0x02, all returned through one registered read port.
module input_devices #(
    parameter int DATA_WIDTH  = 32,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [7:0]            address,
    input  logic                  is_read,
    output logic [DATA_WIDTH-1:0] value,
    output logic                  value_valid,
    input  logic [DATA_WIDTH-1:0] device0_in,
    input  logic [DATA_WIDTH-1:0] device1_data,
    input  logic                  device1_strobe,
    output logic                  device1_irq
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [DATA_WIDTH-1:0] mem_q  [FIFO_DEPTH];

    logic [PTR_W-1:0]      wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0]      rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic [DATA_WIDTH-1:0] value_q, value_d;
    logic                  valid_q, valid_d;
    logic                  irq_q, irq_d;

    logic                  empty, full, popEn, pushEn, ovfSet, statusRead;
    logic [DATA_WIDTH-1:0] statusWord, readData;

    // A pop frees a slot in the same edge, so a strobe against a full FIFO still lands
    // when the CPU pops concurrently; only an unmatched strobe is an overflow.
    always_comb begin
        empty      = (count_q == '0);
        full       = (count_q == FULL_CNT);
        popEn      = is_read && (address == 8'h01) && !empty;
        statusRead = is_read && (address == 8'h02);
        pushEn     = device1_strobe && (!full || popEn);
        ovfSet     = device1_strobe && full && !popEn;

        statusWord       = '0;
        statusWord[0]    = empty;
        statusWord[1]    = full;
        statusWord[2]    = overflow_q;
        statusWord[15:8] = 8'(count_q);

        readData = '0;
        case (address)
            8'h00:   readData = sync_q[SYNC_STAGES-1];
            8'h01:   if (!empty) readData = mem_q[rdPtr_q];
            8'h02:   readData = statusWord;
            default: readData = '0;
        endcase

        wrPtr_d    = pushEn ? wrPtr_q + PTR_W'(1) : wrPtr_q;
        rdPtr_d    = popEn  ? rdPtr_q + PTR_W'(1) : rdPtr_q;
        count_d    = count_q + CNT_W'(pushEn) - CNT_W'(popEn);
        overflow_d = ovfSet | (overflow_q & ~statusRead);
        value_d    = is_read ? readData : value_q;
        valid_d    = is_read;
        irq_d      = (count_d != '0);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            value_q    <= '0;
            valid_q    <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            sync_q[0] <= device0_in;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            value_q    <= value_d;
            valid_q    <= valid_d;
            irq_q      <= irq_d;
        end
    end

    // Storage needs no reset: the pointers and count define which slots are live.
    always_ff @(posedge clk) begin
        if (reset_n && pushEn) mem_q[wrPtr_q] <= device1_data;
    end

    assign value       = value_q;
    assign value_valid = valid_q;
    assign device1_irq = irq_q;

endmodule

// File: tb/tb_input_devices.sv
// Bench for input_devices: a queue-based model predicts every output each cycle,
// with directed scenarios pinned by literal expectations and a randomized phase.
module tb_input_devices;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int SYNC  = 2;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [7:0]    address;
    logic          is_read;
    logic [DW-1:0] value;
    logic          value_valid;
    logic [DW-1:0] device0_in;
    logic [DW-1:0] device1_data;
    logic          device1_strobe;
    logic          device1_irq;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] fifoModel [$];
    logic [DW-1:0] d0Hist    [$];
    bit            ovfModel  = 1'b0;
    logic [DW-1:0] expValue  = '0;
    bit            expValid  = 1'b0;
    bit            expIrq    = 1'b0;
    bit            modelLive = 1'b0;

    input_devices #(
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (DEPTH),
        .SYNC_STAGES(SYNC)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .address       (address),
        .is_read       (is_read),
        .value         (value),
        .value_valid   (value_valid),
        .device0_in    (device0_in),
        .device1_data  (device1_data),
        .device1_strobe(device1_strobe),
        .device1_irq   (device1_irq)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] statusOf(int n, bit ovf);
        return {16'h0, 8'(n), 5'h0, ovf, (n == DEPTH), (n == 0)};
    endfunction

    task automatic checkOutput(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference behaviour: a queue for device 1 and a sample history for device 0.
    task automatic modelStep();
        logic [DW-1:0] rdata;
        int            n;
        bit            pop;
        bit            isFull;
        if (!reset_n) begin
            expValue = '0;
            expValid = 1'b0;
            expIrq   = 1'b0;
            ovfModel = 1'b0;
            fifoModel.delete();
            d0Hist.delete();
            for (int i = 0; i < SYNC; i++) d0Hist.push_back('0);
        end else begin
            n      = fifoModel.size();
            isFull = (n == DEPTH);
            pop    = is_read && (address == 8'h01) && (n > 0);
            case (address)
                8'h00:   rdata = d0Hist[SYNC-1];
                8'h01:   rdata = (n > 0) ? fifoModel[0] : '0;
                8'h02:   rdata = statusOf(n, ovfModel);
                default: rdata = '0;
            endcase
            if (pop) void'(fifoModel.pop_front());
            if (device1_strobe && (!isFull || pop)) fifoModel.push_back(device1_data);
            if (is_read && (address == 8'h02)) ovfModel = 1'b0;
            if (device1_strobe && isFull && !pop) ovfModel = 1'b1;
            expValid = is_read;
            if (is_read) expValue = rdata;
            d0Hist.push_front(device0_in);
            void'(d0Hist.pop_back());
            expIrq = (fifoModel.size() != 0);
        end
        modelLive = 1'b1;
    endtask

    initial begin : modelProc
        forever begin
            @(posedge clk);
            modelStep();
        end
    end

    initial begin : compareProc
        forever begin
            @(negedge clk);
            if (modelLive) begin
                checkOutput("value", value, expValue);
                checkOutput("value_valid", {31'h0, value_valid}, {31'h0, expValid});
                checkOutput("irq", {31'h0, device1_irq}, {31'h0, expIrq});
            end
        end
    end

    task automatic applyStimulus(bit rd, logic [7:0] addr, bit stb, logic [DW-1:0] data);
        is_read        = rd;
        address        = addr;
        device1_strobe = stb;
        device1_data   = data;
        @(posedge clk);
        #1;
        is_read        = 1'b0;
        device1_strobe = 1'b0;
    endtask

    logic [DW-1:0] rd0 [4];
    int            sel;

    initial begin : stimulus
        reset_n        = 1'b0;
        is_read        = 1'b1;
        address        = 8'h01;
        device1_strobe = 1'b1;
        device1_data   = 32'h55;
        device0_in     = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_value", value, '0);
        checkOutput("rst_valid", {31'h0, value_valid}, 32'h0);
        checkOutput("rst_irq", {31'h0, device1_irq}, 32'h0);
        reset_n        = 1'b1;
        is_read        = 1'b0;
        device1_strobe = 1'b0;
        applyStimulus(1, 8'h02, 0, '0);
        checkOutput("rst_status", value, 32'h00000001);

        device0_in = 32'hDEADBEEF;
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1, 8'h00, 0, '0);
            rd0[k] = value;
        end
        checkOutput("d0_read0", rd0[0], 32'h0);
        checkOutput("d0_read1", rd0[1], 32'h0);
        checkOutput("d0_read2", rd0[2], 32'hDEADBEEF);
        checkOutput("d0_read3", rd0[3], 32'hDEADBEEF);

        applyStimulus(0, 8'h00, 1, 32'h11);
        applyStimulus(0, 8'h00, 1, 32'h22);
        applyStimulus(0, 8'h00, 1, 32'h33);
        applyStimulus(1, 8'h01, 0, '0);
        checkOutput("order_pop1", value, 32'h11);
        applyStimulus(1, 8'h01, 0, '0);
        checkOutput("order_pop2", value, 32'h22);
        checkOutput("order_irq_hi", {31'h0, device1_irq}, 32'h1);
        applyStimulus(1, 8'h01, 0, '0);
        checkOutput("order_pop3", value, 32'h33);
        checkOutput("order_irq_lo", {31'h0, device1_irq}, 32'h0);
        applyStimulus(1, 8'h01, 0, '0);
        checkOutput("order_pop_empty", value, 32'h0);
        applyStimulus(1, 8'h02, 0, '0);
        checkOutput("order_status", value, 32'h00000001);

        for (int i = 0; i < 5; i++) applyStimulus(0, 8'h00, 1, 32'hA0 + i);
        applyStimulus(1, 8'h02, 0, '0);
        checkOutput("ovf_status1", value, 32'h00000406);
        applyStimulus(1, 8'h02, 0, '0);
        checkOutput("ovf_status2", value, 32'h00000402);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 8'h01, 0, '0);
            checkOutput("ovf_pop", value, 32'hA0 + i);
        end

        for (int i = 0; i < 4; i++) applyStimulus(0, 8'h00, 1, 32'hB0 + i);
        applyStimulus(1, 8'h01, 1, 32'hB4);
        checkOutput("fullpp_pop", value, 32'hB0);
        applyStimulus(1, 8'h02, 0, '0);
        checkOutput("fullpp_status", value, 32'h00000402);
        for (int i = 1; i < 5; i++) begin
            applyStimulus(1, 8'h01, 0, '0);
            checkOutput("fullpp_drain", value, 32'hB0 + i);
        end

        applyStimulus(1, 8'h01, 1, 32'hC5);
        checkOutput("emptypp_pop", value, 32'h0);
        applyStimulus(1, 8'h02, 0, '0);
        checkOutput("emptypp_status", value, 32'h00000100);
        applyStimulus(1, 8'h01, 0, '0);
        checkOutput("emptypp_drain", value, 32'hC5);

        applyStimulus(0, 8'h00, 1, 32'hD1);
        applyStimulus(1, 8'h03, 0, '0);
        checkOutput("unmapped_03", value, 32'h0);
        applyStimulus(1, 8'hFF, 0, '0);
        checkOutput("unmapped_ff", value, 32'h0);
        applyStimulus(1, 8'h02, 0, '0);
        checkOutput("unmapped_status", value, 32'h00000100);
        applyStimulus(1, 8'h01, 0, '0);
        checkOutput("unmapped_drain", value, 32'hD1);

        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 8'h00, 1, 32'hE0 + i);
            applyStimulus(1, 8'h01, 0, '0);
            checkOutput("wrap_pop", value, 32'hE0 + i);
        end

        repeat (400) begin
            reset_n        = ($urandom_range(0, 59) != 0);
            is_read        = $urandom_range(0, 1) != 0;
            sel            = $urandom_range(0, 7);
            case (sel)
                0:       address = 8'h00;
                1, 2, 3: address = 8'h01;
                4, 5:    address = 8'h02;
                default: address = 8'($urandom_range(3, 255));
            endcase
            device1_strobe = ($urandom_range(0, 2) == 0);
            device1_data   = $urandom;
            device0_in     = $urandom;
            @(posedge clk);
            #1;
        end
        reset_n        = 1'b1;
        is_read        = 1'b0;
        device1_strobe = 1'b0;
        repeat (3) @(posedge clk);
        #6;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/input_devices.md
Name: input_devices

Overview:
- Read-side counterpart to the CPU output-device register file: the CPU reads peripheral inputs by 8-bit address.
- Device 0 is a level port, such as switches. Its value is resynchronised and read directly.
- Device 1 is an event port, such as a keypad. Each strobed word is queued in a small FIFO, and the CPU pops the words one at a time.
- The block sits on the CPU I/O read path, beside the output-device block, and shares its 8-bit address and 32-bit data conventions.

Parameters:
- DATA_WIDTH, 32: width of device data and of the read bus.
- FIFO_DEPTH, 4: device 1 queue depth. Power of 2, range 2..128.
- SYNC_STAGES, 2: synchroniser flops on the device 0 input. Minimum 2.

Ports:
- clk  input  1  system clock. All state updates on the rising edge.
- reset_n  input  1  synchronous, active-low reset.
- address  input  8  CPU read address.
- is_read  input  1  CPU read request, sampled on the rising edge.
- value  output  DATA_WIDTH  read data, registered.
- value_valid  output  1  single-cycle pulse: value holds the data for the read request of the previous cycle.
- device0_in  input  DATA_WIDTH  asynchronous level input.
- device1_data  input  DATA_WIDTH  event data, qualified by device1_strobe.
- device1_strobe  input  1  one-cycle push request, synchronous to clk.
- device1_irq  output  1  high while the FIFO is non-empty. Registered.

Behaviour:
- Reset (reset_n low at a rising edge):
  - value = 0, value_valid = 0, device1_irq = 0.
  - Synchroniser stages cleared to 0.
  - FIFO emptied: pointers 0, count 0.
  - Overflow flag cleared.
  - Reset takes priority over any read or strobe in the same cycle; a read in flight is dropped (no value_valid).
- Device 0 path:
  - device0_in passes through SYNC_STAGES flops.
  - A read returns the last stage.
  - Input change to read-visible latency = SYNC_STAGES cycles.
- Read latency:
  - is_read at edge N causes value and value_valid to update at edge N+1.
  - value_valid is high for exactly one cycle per request. Back-to-back reads are allowed, one per cycle.
  - When no read is pending, value holds its last value and value_valid = 0.
- Address map:
  - 0x00: synchronised device 0 value.
  - 0x01: FIFO head.
    - Non-empty: returns the head and pops it in the same edge.
    - Empty: returns 0, no pop, no error.
  - 0x02: status word.
    - bit0 = empty, bit1 = full, bit2 = overflow (sticky).
    - bits[15:8] = count, zero-extended.
    - All other bits 0.
    - The read returns the pre-clear overflow value, then clears overflow at the same edge.
  - Any other address: returns 0, no side effects.
- FIFO push:
  - device1_strobe high at an edge pushes device1_data when not full. Write pointer wraps modulo FIFO_DEPTH.
  - Strobe while full with no simultaneous pop: data is dropped, overflow is set, and FIFO contents are unchanged.
  - Strobe while full with a simultaneous pop (read at 0x01): both occur, count stays at FIFO_DEPTH, no overflow.
  - Strobe while empty with a simultaneous pop: the pop is a no-op returning 0, the push succeeds, count = 1.
- Overflow flag priority:
  - Overflow set and a status read in the same cycle: the read returns the pre-edge flag, and the flag ends set (set wins over clear).
- Count:
  - Range 0..FIFO_DEPTH.
  - full = (count == FIFO_DEPTH), empty = (count == 0).
  - Pointers are log2(FIFO_DEPTH) bits wide and wrap silently.
- device1_irq equals the registered value of !empty after the edge, so it lags the state change by 0 cycles relative to count.

Test Plan:
- Reset behaviour: drive reset_n = 0 for 2 cycles with is_read = 1, address = 0x01, and strobes active → value = 0, value_valid = 0, device1_irq = 0; status read after release = 0x00000001.
- Device 0 latency: set device0_in = 0xDEADBEEF at cycle 0 and read address 0x00 every cycle → value shows 0xDEADBEEF first in the response to the read issued at edge 2 (SYNC_STAGES = 2), with value_valid pulsing each cycle.
- FIFO ordering: strobe 0x11, 0x22, 0x33, then read 0x01 four times → returns 0x11, 0x22, 0x33, 0x0; status then = 0x00000001; device1_irq falls after the third pop.
- Overflow: strobe 5 words (0xA0..0xA4) with depth 4 → status = 0x00000406.
  - Second status read → 0x00000402.
  - Pops return 0xA0..0xA3; 0xA4 is lost.
- Full with simultaneous push/pop: with the FIFO full (0xB0..0xB3), pop and strobe 0xB4 in the same cycle → returns 0xB0, count stays 4, overflow stays 0, and later pops return 0xB1..0xB4.
- Unmapped address and wrap: read addresses 0x03 and 0xFF → 0 with no side effects; 10 push/pop pairs through a depth-4 FIFO all return in order (pointer wrap).
